usb_device_fsm: RTL and testbench
=================================

USB_DEVICE_FSM -- requirements
Module: usb_device_fsm

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles the block waits for a DATA0 or host handshake before abandoning a transaction.
REQ-002 Parameter MAX_RETRY, default 8: maximum DATA0 transmissions per IN transaction.
REQ-003 Ports (clock and reset first):
- clock  in  1  sole clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rec_OUT  in  1  1-cycle pulse: OUT token received.
- rec_IN  in  1  1-cycle pulse: IN token received.
- rec_endp  in  4  token endpoint; valid with rec_OUT/rec_IN.
- rec_DATA0  in  1  1-cycle pulse: DATA0 packet received.
- data_valid  in  1  CRC good; qualifies rec_DATA0 in the same cycle.
- data_rec  in  64  DATA0 payload; valid with rec_DATA0.
- rec_ACK, rec_NAK  in  1 each  1-cycle pulses: host handshake received.
- sent  in  1  1-cycle pulse: packet sender finished current packet.
- send_DATA0, send_ACK, send_NAK  out  1 each  1-cycle request pulses to packet sender.
- tx_data  out  64  DATA0 payload; stable from send_DATA0 until sent.
- sending  out  1  high from any send_* pulse through the cycle sent is seen.
- mem_addr  out  16  latched memory page.
- mem_wdata  out  64  write data.
- mem_we, mem_re  out  1 each  1-cycle strobes; mem_rdata valid the cycle after mem_re.
- mem_rdata  in  64  memory read data.
- addr_valid  out  1  a page has been latched since reset.
- write_done, read_done, read_fail  out  1 each  1-cycle status pulses.

Function
REQ-004 States: IDLE, OUT_WAIT_DATA, OUT_SEND_ACK, OUT_SEND_NAK, IN_MEM_READ, IN_SEND_DATA, IN_WAIT_HS, IN_SEND_NAK.
REQ-005 IDLE: rec_OUT with endp 4 or 8 -> OUT_WAIT_DATA, endpoint latched; rec_IN with endp 8 -> IN_MEM_READ if addr_valid, else IN_SEND_NAK; any other endpoint ignored, stay IDLE.
REQ-006 Tokens arriving outside IDLE are ignored.
REQ-007 OUT_WAIT_DATA: rec_DATA0 with data_valid=1 -> OUT_SEND_ACK; rec_DATA0 with data_valid=0 -> OUT_SEND_NAK; no DATA0 within TIMEOUT cycles of state entry -> IDLE, no packet sent.
REQ-008 Endp 4 with valid DATA0: mem_addr <= data_rec[63:48], addr_valid <= 1, registered the cycle after rec_DATA0.
REQ-009 Endp 8 with valid DATA0 and addr_valid=1: mem_wdata <= data_rec; mem_we pulsed the cycle after rec_DATA0.
REQ-010 Endp 8 with valid DATA0 and addr_valid=0: go to OUT_SEND_NAK instead; no mem_we.
REQ-011 OUT_SEND_ACK/OUT_SEND_NAK/IN_SEND_NAK: pulse the corresponding send_* on state entry; on sent -> IDLE; write_done pulses with sent in OUT_SEND_ACK for endp 8 only.
REQ-012 IN_MEM_READ: mem_re pulse on entry; next cycle tx_data <= mem_rdata, retry counter <= 1, send_DATA0 pulse, -> IN_SEND_DATA.
REQ-013 IN_SEND_DATA: wait for sent, then -> IN_WAIT_HS with timeout counter cleared.
REQ-014 IN_WAIT_HS: rec_ACK -> read_done pulse, IDLE; rec_NAK or TIMEOUT expiry -> if retry counter < MAX_RETRY, increment, re-pulse send_DATA0 with unchanged tx_data, -> IN_SEND_DATA; else read_fail pulse, IDLE.
REQ-015 rec_ACK and rec_NAK in the same cycle: treated as NAK.
REQ-016 Timeout counter 8 bits, cleared on every state entry, saturates; expiry = count reaching TIMEOUT.
REQ-017 Retry counter 4 bits; no wrap for MAX_RETRY <= 15.
REQ-018 Every send_*, mem_we, mem_re and status pulse is exactly one cycle wide.

Reset
REQ-019 reset_n low: state IDLE; all pulses, sending, addr_valid 0; mem_addr, mem_wdata, tx_data, counters 0.
REQ-020 Reset mid-transaction abandons it immediately; no status pulse, memory strobe or send_* on release.

Verification
REQ-021 OUT endp 4, DATA0 0xABCD_0000_0000_0000 valid -> mem_addr=0xABCD, addr_valid=1, send_ACK, no mem_we.
REQ-022 After REQ-021, OUT endp 8, DATA0 0x1122_3344_5566_7788 valid -> mem_we once with mem_wdata=that value, send_ACK, write_done on sent.
REQ-023 IN endp 8, mem_rdata=0xDEAD_BEEF_0000_0001 -> mem_re, send_DATA0, tx_data equal; host rec_ACK -> read_done.
REQ-024 IN endp 8, host NAKs every DATA0 -> exactly 8 send_DATA0 pulses, then read_fail, IDLE.
REQ-025 OUT endp 8 before any address -> send_NAK, no mem_we; OUT endp 4 with data_valid=0 -> send_NAK, addr_valid stays 0.
REQ-026 OUT endp 4, no DATA0 for 255 cycles -> IDLE, no send_*; reset asserted during IN_WAIT_HS -> all outputs 0, no read_done/read_fail.

Source files
------------

// File: rtl/usb_device_fsm.sv
// usb_device_fsm: USB device-side transaction controller.
// Handles OUT (page latch / memory write) and IN (memory read with retries).
module usb_device_fsm #(
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rec_OUT,
   input  logic        rec_IN,
   input  logic [3:0]  rec_endp,
   input  logic        rec_DATA0,
   input  logic        data_valid,
   input  logic [63:0] data_rec,
   input  logic        rec_ACK,
   input  logic        rec_NAK,
   input  logic        sent,
   output logic        send_DATA0,
   output logic        send_ACK,
   output logic        send_NAK,
   output logic [63:0] tx_data,
   output logic        sending,
   output logic [15:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [63:0] mem_rdata,
   output logic        addr_valid,
   output logic        write_done,
   output logic        read_done,
   output logic        read_fail
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_OUT_WAIT = 3'd1;
   localparam logic [2:0] S_OUT_ACK  = 3'd2;
   localparam logic [2:0] S_OUT_NAK  = 3'd3;
   localparam logic [2:0] S_IN_RD    = 3'd4;
   localparam logic [2:0] S_IN_DATA  = 3'd5;
   localparam logic [2:0] S_IN_HS    = 3'd6;
   localparam logic [2:0] S_IN_NAK   = 3'd7;

   localparam logic [7:0] L_TMO  = 8'(TIMEOUT);
   localparam logic [3:0] L_RMAX = 4'(MAX_RETRY);
   localparam logic [3:0] L_EP_A = 4'd4;
   localparam logic [3:0] L_EP_D = 4'd8;

   logic [2:0]  r_state;
   logic [3:0]  r_endp;
   logic [7:0]  r_tmo;
   logic [3:0]  r_retry;
   logic [15:0] r_mem_addr;
   logic [63:0] r_mem_wdata;
   logic [63:0] r_tx_data;
   logic        r_addr_valid;
   logic        r_send_d0;
   logic        r_send_ack;
   logic        r_send_nak;
   logic        r_sending;
   logic        r_mem_we;
   logic        r_mem_re;
   logic        r_read_done;
   logic        r_read_fail;

   logic        w_out_ep;
   logic        w_tmo_exp;
   logic        w_hs_ack;
   logic [7:0]  w_tmo_inc;

   assign w_out_ep  = (rec_endp == L_EP_A) || (rec_endp == L_EP_D);
   assign w_tmo_exp = (r_tmo == L_TMO);
   assign w_hs_ack  = rec_ACK && !rec_NAK;
   assign w_tmo_inc = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;

   // Transaction sequencer: state, counters, latched data and pulse requests
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_endp       <= 4'd0;
         r_tmo        <= 8'd0;
         r_retry      <= 4'd0;
         r_mem_addr   <= 16'd0;
         r_mem_wdata  <= 64'd0;
         r_tx_data    <= 64'd0;
         r_addr_valid <= 1'b0;
         r_send_d0    <= 1'b0;
         r_send_ack   <= 1'b0;
         r_send_nak   <= 1'b0;
         r_sending    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_re     <= 1'b0;
         r_read_done  <= 1'b0;
         r_read_fail  <= 1'b0;
      end else begin
         r_send_d0   <= 1'b0;
         r_send_ack  <= 1'b0;
         r_send_nak  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_re    <= 1'b0;
         r_read_done <= 1'b0;
         r_read_fail <= 1'b0;
         r_tmo       <= w_tmo_inc;
         case (r_state)
            S_IDLE: begin
               if (rec_OUT && w_out_ep) begin
                  r_endp  <= rec_endp;
                  r_tmo   <= 8'd0;
                  r_state <= S_OUT_WAIT;
               end else if (rec_IN && rec_endp == L_EP_D) begin
                  r_endp <= rec_endp;
                  r_tmo  <= 8'd0;
                  if (r_addr_valid) begin
                     r_mem_re <= 1'b1;
                     r_state  <= S_IN_RD;
                  end else begin
                     r_send_nak <= 1'b1;
                     r_sending  <= 1'b1;
                     r_state    <= S_IN_NAK;
                  end
               end
            end
            S_OUT_WAIT: begin
               if (rec_DATA0) begin
                  r_tmo     <= 8'd0;
                  r_sending <= 1'b1;
                  if (!data_valid) begin
                     r_send_nak <= 1'b1;
                     r_state    <= S_OUT_NAK;
                  end else if (r_endp == L_EP_A) begin
                     r_mem_addr   <= data_rec[63:48];
                     r_addr_valid <= 1'b1;
                     r_send_ack   <= 1'b1;
                     r_state      <= S_OUT_ACK;
                  end else if (r_addr_valid) begin
                     r_mem_wdata <= data_rec;
                     r_mem_we    <= 1'b1;
                     r_send_ack  <= 1'b1;
                     r_state     <= S_OUT_ACK;
                  end else begin
                     r_send_nak <= 1'b1;
                     r_state    <= S_OUT_NAK;
                  end
               end else if (w_tmo_exp) begin
                  r_tmo   <= 8'd0;
                  r_state <= S_IDLE;
               end
            end
            S_OUT_ACK, S_OUT_NAK, S_IN_NAK: begin
               if (sent) begin
                  r_sending <= 1'b0;
                  r_tmo     <= 8'd0;
                  r_state   <= S_IDLE;
               end
            end
            S_IN_RD: begin
               // first cycle issues the read; read data arrives one cycle later
               if (!r_mem_re) begin
                  r_tx_data <= mem_rdata;
                  r_retry   <= 4'd1;
                  r_send_d0 <= 1'b1;
                  r_sending <= 1'b1;
                  r_tmo     <= 8'd0;
                  r_state   <= S_IN_DATA;
               end
            end
            S_IN_DATA: begin
               if (sent) begin
                  r_sending <= 1'b0;
                  r_tmo     <= 8'd0;
                  r_state   <= S_IN_HS;
               end
            end
            S_IN_HS: begin
               if (w_hs_ack) begin
                  r_read_done <= 1'b1;
                  r_tmo       <= 8'd0;
                  r_state     <= S_IDLE;
               end else if (rec_NAK || w_tmo_exp) begin
                  r_tmo <= 8'd0;
                  if (r_retry < L_RMAX) begin
                     r_retry   <= r_retry + 4'd1;
                     r_send_d0 <= 1'b1;
                     r_sending <= 1'b1;
                     r_state   <= S_IN_DATA;
                  end else begin
                     r_read_fail <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign write_done = (r_state == S_OUT_ACK) && sent && (r_endp == L_EP_D);
   assign send_DATA0 = r_send_d0;
   assign send_ACK   = r_send_ack;
   assign send_NAK   = r_send_nak;
   assign tx_data    = r_tx_data;
   assign sending    = r_sending;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_we     = r_mem_we;
   assign mem_re     = r_mem_re;
   assign addr_valid = r_addr_valid;
   assign read_done  = r_read_done;
   assign read_fail  = r_read_fail;

endmodule

// File: tb/tb_usb_device_fsm.sv
// tb_usb_device_fsm: directed table, corner sequences and random
// transactions against a transaction-level reference model.
module tb_usb_device_fsm;

   localparam int TIMEOUT   = 255;
   localparam int MAX_RETRY = 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rec_OUT = 1'b0;
   logic        rec_IN = 1'b0;
   logic [3:0]  rec_endp = 4'd0;
   logic        rec_DATA0 = 1'b0;
   logic        data_valid = 1'b0;
   logic [63:0] data_rec = 64'd0;
   logic        rec_ACK = 1'b0;
   logic        rec_NAK = 1'b0;
   logic        sent = 1'b0;
   logic [63:0] mem_rdata = 64'd0;
   logic        send_DATA0, send_ACK, send_NAK, sending;
   logic [63:0] tx_data, mem_wdata;
   logic [15:0] mem_addr;
   logic        mem_we, mem_re, addr_valid;
   logic        write_done, read_done, read_fail;

   always #5 clock = ~clock;

   usb_device_fsm #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
      .clock(clock), .reset_n(reset_n),
      .rec_OUT(rec_OUT), .rec_IN(rec_IN), .rec_endp(rec_endp),
      .rec_DATA0(rec_DATA0), .data_valid(data_valid),
      .data_rec(data_rec), .rec_ACK(rec_ACK), .rec_NAK(rec_NAK),
      .sent(sent), .send_DATA0(send_DATA0), .send_ACK(send_ACK),
      .send_NAK(send_NAK), .tx_data(tx_data), .sending(sending),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_re(mem_re), .mem_rdata(mem_rdata),
      .addr_valid(addr_valid), .write_done(write_done),
      .read_done(read_done), .read_fail(read_fail)
   );

   typedef struct {
      bit          is_in;
      logic [3:0]  endp;
      bit          valid;
      logic [63:0] data;
      int          naks;
      bit          both;
      int e_ack, e_nak, e_d0, e_we, e_re, e_wd, e_rd, e_rf;
      bit          e_av;
      logic [15:0] e_addr;
      logic [63:0] e_val;
   } vec_t;

   int n_vec = 0;
   int n_miss = 0;
   int c_ack, c_nak, c_d0, c_we, c_re, c_wd, c_rd, c_rf;
   int wide_viol = 0;
   int tx_unstable = 0;
   logic [63:0] last_wdata = 64'd0;
   logic [63:0] tx_ref = 64'd0;
   bit          in_data = 1'b0;
   logic [7:0]  prev_p = 8'd0;
   logic [7:0]  cur_p;

   // external memory contents and the model's view of them
   logic [63:0] mem_img [logic [15:0]];
   logic [63:0] ref_mem [logic [15:0]];
   bit          ref_av = 1'b0;
   logic [15:0] ref_addr = 16'd0;

   vec_t tbl [13];

   function automatic logic [63:0] mem_init(input logic [15:0] a);
      if (a == 16'h0042) return 64'hDEAD_BEEF_0000_0001;
      return {a, ~a, a ^ 16'hA5A5, 16'h0F0F};
   endfunction

   function automatic logic [63:0] mem_rd(input logic [15:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return mem_init(a);
   endfunction

   // pulse counting, pulse-width and tx_data stability monitor
   always @(negedge clock) begin
      cur_p = {send_ACK, send_NAK, send_DATA0, mem_we,
               mem_re, write_done, read_done, read_fail};
      if ((cur_p & prev_p) != 8'd0) wide_viol++;
      prev_p = cur_p;
      if (send_ACK) c_ack++;
      if (send_NAK) c_nak++;
      if (mem_re) c_re++;
      if (write_done) c_wd++;
      if (read_done) c_rd++;
      if (read_fail) c_rf++;
      if (mem_we) begin
         c_we++;
         last_wdata = mem_wdata;
         mem_img[mem_addr] = mem_wdata;
      end
      if (send_DATA0) begin
         c_d0++;
         tx_ref = tx_data;
         in_data = 1'b1;
      end else if (send_ACK || send_NAK) begin
         in_data = 1'b0;
      end
      if (sending && in_data && tx_data != tx_ref) tx_unstable++;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      c_ack = 0; c_nak = 0; c_d0 = 0; c_we = 0;
      c_re = 0; c_wd = 0; c_rd = 0; c_rf = 0;
   endtask

   task automatic pulse_sent();
      cyc();
      cyc();
      sent = 1'b1;
      cyc();
      sent = 1'b0;
   endtask

   // waits for the DUT to start sending; plays the memory on mem_re
   task automatic wait_sending(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (mem_re) mem_rdata = mem_rd(mem_addr);
         if (sending) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic run_out(input logic [3:0] ep, input bit va,
                          input logic [63:0] d);
      bit ok;
      rec_OUT = 1'b1; rec_endp = ep;
      cyc();
      rec_OUT = 1'b0; rec_endp = 4'd0;
      cyc();
      rec_DATA0 = 1'b1; data_valid = va; data_rec = d;
      cyc();
      rec_DATA0 = 1'b0; data_valid = 1'b0; data_rec = 64'd0;
      wait_sending(6, ok);
      if (ok) pulse_sent();
      repeat (3) cyc();
   endtask

   task automatic run_in(input logic [3:0] ep, input int nk,
                         input bit bo, input bit silent);
      bit ok;
      bit is_d;
      rec_IN = 1'b1; rec_endp = ep;
      cyc();
      rec_IN = 1'b0; rec_endp = 4'd0;
      for (int k = 0; k < 12; k++) begin
         wait_sending(silent ? TIMEOUT + 20 : 8, ok);
         if (!ok) break;
         is_d = send_DATA0;
         pulse_sent();
         if (!is_d) break;
         cyc();
         if (!silent) begin
            if (k < nk) begin
               rec_NAK = 1'b1;
               rec_ACK = bo;
            end else begin
               rec_ACK = 1'b1;
            end
            cyc();
            rec_NAK = 1'b0;
            rec_ACK = 1'b0;
         end
      end
      repeat (3) cyc();
   endtask

   function automatic vec_t mk(
      input bit ii, input logic [3:0] ep, input bit va,
      input logic [63:0] d, input int nk, input bit bo,
      input int a, input int n, input int d0, input int we,
      input int re, input int wd, input int rd, input int rf,
      input bit av, input logic [15:0] ad, input logic [63:0] val);
      vec_t v;
      v.is_in = ii; v.endp = ep; v.valid = va; v.data = d;
      v.naks = nk; v.both = bo;
      v.e_ack = a; v.e_nak = n; v.e_d0 = d0; v.e_we = we;
      v.e_re = re; v.e_wd = wd; v.e_rd = rd; v.e_rf = rf;
      v.e_av = av; v.e_addr = ad; v.e_val = val;
      return v;
   endfunction

   // transaction-level reference: outcome of one transaction from the rules
   task automatic model(input vec_t vi, output vec_t vo);
      vo = vi;
      vo.e_ack = 0; vo.e_nak = 0; vo.e_d0 = 0; vo.e_we = 0;
      vo.e_re = 0; vo.e_wd = 0; vo.e_rd = 0; vo.e_rf = 0;
      vo.e_val = 64'd0;
      if (!vi.is_in) begin
         if (vi.endp == 4'd4) begin
            if (vi.valid) begin
               ref_av = 1'b1;
               ref_addr = vi.data[63:48];
               vo.e_ack = 1;
            end else begin
               vo.e_nak = 1;
            end
         end else if (vi.endp == 4'd8) begin
            if (vi.valid && ref_av) begin
               vo.e_ack = 1; vo.e_we = 1; vo.e_wd = 1;
               vo.e_val = vi.data;
               ref_mem[ref_addr] = vi.data;
            end else begin
               vo.e_nak = 1;
            end
         end
      end else if (vi.endp == 4'd8) begin
         if (!ref_av) begin
            vo.e_nak = 1;
         end else begin
            vo.e_re = 1;
            vo.e_val = ref_mem.exists(ref_addr) ? ref_mem[ref_addr]
                                                : mem_init(ref_addr);
            vo.e_d0 = (vi.naks + 1 < MAX_RETRY) ? vi.naks + 1 : MAX_RETRY;
            if (vi.naks >= MAX_RETRY) vo.e_rf = 1;
            else vo.e_rd = 1;
         end
      end
      vo.e_av = ref_av;
      vo.e_addr = ref_addr;
   endtask

   task automatic apply(input vec_t v, input string tag);
      clr();
      if (v.is_in) run_in(v.endp, v.naks, v.both, 1'b0);
      else run_out(v.endp, v.valid, v.data);
      chk({tag, ".ack"}, 64'(c_ack), 64'(v.e_ack));
      chk({tag, ".nak"}, 64'(c_nak), 64'(v.e_nak));
      chk({tag, ".data0"}, 64'(c_d0), 64'(v.e_d0));
      chk({tag, ".we"}, 64'(c_we), 64'(v.e_we));
      chk({tag, ".re"}, 64'(c_re), 64'(v.e_re));
      chk({tag, ".wdone"}, 64'(c_wd), 64'(v.e_wd));
      chk({tag, ".rdone"}, 64'(c_rd), 64'(v.e_rd));
      chk({tag, ".rfail"}, 64'(c_rf), 64'(v.e_rf));
      chk({tag, ".av"}, 64'(addr_valid), 64'(v.e_av));
      chk({tag, ".addr"}, 64'(mem_addr), 64'(v.e_addr));
      if (v.e_we != 0) chk({tag, ".wdata"}, last_wdata, v.e_val);
      if (v.e_d0 != 0) chk({tag, ".tx"}, tx_ref, v.e_val);
   endtask

   initial begin : main
      vec_t v;
      vec_t vm;
      logic [15:0] pg;
      int r;

      tbl[0]  = mk(1, 8, 0, 64'd0, 0, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 64'd0);
      tbl[1]  = mk(0, 8, 1, 64'h1122_3344_5566_7788, 0, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 64'd0);
      tbl[2]  = mk(0, 4, 0, 64'hABCD_0000_0000_0000, 0, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 64'd0);
      tbl[3]  = mk(0, 4, 1, 64'hABCD_0000_0000_0000, 0, 0,
                   1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hABCD, 64'd0);
      tbl[4]  = mk(0, 8, 1, 64'h1122_3344_5566_7788, 0, 0,
                   1, 0, 0, 1, 0, 1, 0, 0, 1, 16'hABCD,
                   64'h1122_3344_5566_7788);
      tbl[5]  = mk(1, 8, 0, 64'd0, 0, 0,
                   0, 0, 1, 0, 1, 0, 1, 0, 1, 16'hABCD,
                   64'h1122_3344_5566_7788);
      tbl[6]  = mk(0, 4, 1, 64'h0042_0000_0000_0000, 0, 0,
                   1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0042, 64'd0);
      tbl[7]  = mk(1, 8, 0, 64'd0, 2, 1,
                   0, 0, 3, 0, 1, 0, 1, 0, 1, 16'h0042,
                   64'hDEAD_BEEF_0000_0001);
      tbl[8]  = mk(1, 8, 0, 64'd0, 8, 0,
                   0, 0, 8, 0, 1, 0, 0, 1, 1, 16'h0042,
                   64'hDEAD_BEEF_0000_0001);
      tbl[9]  = mk(1, 8, 0, 64'd0, 7, 0,
                   0, 0, 8, 0, 1, 0, 1, 0, 1, 16'h0042,
                   64'hDEAD_BEEF_0000_0001);
      tbl[10] = mk(0, 5, 1, 64'h9999_0000_0000_0000, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0042, 64'd0);
      tbl[11] = mk(1, 4, 0, 64'd0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0042, 64'd0);
      tbl[12] = mk(0, 8, 0, 64'h5555_0000_0000_0000, 0, 0,
                   0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0042, 64'd0);

      clr();
      #12;
      chk("reset.ctrl",
          64'({send_DATA0, send_ACK, send_NAK, sending, mem_we, mem_re,
               addr_valid, write_done, read_done, read_fail}), 64'd0);
      chk("reset.tx", tx_data, 64'd0);
      chk("reset.addr", 64'(mem_addr), 64'd0);
      chk("reset.wdata", mem_wdata, 64'd0);
      cyc();
      reset_n = 1'b1;
      cyc();

      for (int i = 0; i < 13; i++) begin
         model(tbl[i], vm);
         apply(tbl[i], $sformatf("tbl%0d", i));
      end

      // DATA0 on the last cycle of the window is still accepted
      clr();
      rec_OUT = 1'b1; rec_endp = 4'd4;
      cyc();
      rec_OUT = 1'b0; rec_endp = 4'd0;
      repeat (TIMEOUT - 1) cyc();
      rec_DATA0 = 1'b1; data_valid = 1'b1;
      data_rec = 64'h7777_0000_0000_0000;
      cyc();
      rec_DATA0 = 1'b0; data_valid = 1'b0; data_rec = 64'd0;
      pulse_sent();
      repeat (3) cyc();
      chk("tmo_edge.ack", 64'(c_ack), 64'd1);
      chk("tmo_edge.addr", 64'(mem_addr), 64'h7777);

      // DATA0 after the window is ignored; nothing is sent
      clr();
      rec_OUT = 1'b1; rec_endp = 4'd4;
      cyc();
      rec_OUT = 1'b0; rec_endp = 4'd0;
      repeat (TIMEOUT + 1) cyc();
      rec_DATA0 = 1'b1; data_valid = 1'b1;
      data_rec = 64'h5555_0000_0000_0000;
      cyc();
      rec_DATA0 = 1'b0; data_valid = 1'b0; data_rec = 64'd0;
      repeat (10) cyc();
      chk("tmo_late.sends", 64'(c_ack + c_nak + c_d0), 64'd0);
      chk("tmo_late.addr", 64'(mem_addr), 64'h7777);
      chk("tmo_late.sending", 64'(sending), 64'd0);

      // silent host: every DATA0 times out, eight attempts then failure
      clr();
      run_in(4'd8, 0, 1'b0, 1'b1);
      chk("silent.data0", 64'(c_d0), 64'(MAX_RETRY));
      chk("silent.rfail", 64'(c_rf), 64'd1);
      chk("silent.rdone", 64'(c_rd), 64'd0);
      chk("silent.tx", tx_ref, mem_init(16'h7777));

      // reset while waiting for the host handshake
      begin : rst_mid
         bit ok;
         clr();
         rec_IN = 1'b1; rec_endp = 4'd8;
         cyc();
         rec_IN = 1'b0; rec_endp = 4'd0;
         wait_sending(8, ok);
         chk("rst_mid.started", 64'(ok), 64'd1);
         pulse_sent();
         cyc();
         reset_n = 1'b0;
         #2;
         chk("rst_mid.ctrl",
             64'({send_DATA0, send_ACK, send_NAK, sending, mem_we, mem_re,
                  addr_valid, write_done, read_done, read_fail}), 64'd0);
         chk("rst_mid.data", 64'(|{tx_data, mem_wdata, mem_addr}), 64'd0);
         cyc();
         cyc();
         clr();
         reset_n = 1'b1;
         repeat (TIMEOUT + 20) cyc();
         chk("rst_mid.quiet",
             64'(c_ack + c_nak + c_d0 + c_we + c_re + c_wd + c_rd + c_rf),
             64'd0);
         chk("rst_mid.av", 64'(addr_valid), 64'd0);
         ref_av = 1'b0;
         ref_addr = 16'd0;
      end

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case ($urandom_range(0, 3))
            0: pg = 16'h0042;
            1: pg = 16'h1000;
            2: pg = 16'hABCD;
            default: pg = 16'($urandom);
         endcase
         v = mk(0, 4, 1, {pg, 32'($urandom), 16'($urandom)}, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 64'd0);
         case (r)
            0, 1: ;
            2: v.valid = 1'b0;
            3, 4: begin
               v.endp = 4'd8;
               v.data = {32'($urandom), 32'($urandom)};
            end
            5: begin
               v.endp = 4'd8;
               v.valid = 1'b0;
            end
            6, 9: begin
               v.is_in = (r == 9);
               v.endp = 4'($urandom_range(0, 15));
               if (v.endp == 4'd4 || v.endp == 4'd8) v.endp = v.endp + 4'd1;
            end
            default: begin
               v.is_in = 1'b1;
               v.endp = 4'd8;
               v.naks = $urandom_range(0, 9);
               v.both = 1'($urandom_range(0, 1));
            end
         endcase
         model(v, vm);
         apply(vm, $sformatf("rnd%0d", i));
      end

      chk("pulse_width", 64'(wide_viol), 64'd0);
      chk("tx_stable", 64'(tx_unstable), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
